vga_fb_arbiter: RTL and testbench
=================================

// Module: vga_fb_arbiter
// PURPOSE
//  Owns the single-port frame-buffer RAM behind the Sincronizador VGA timing generator.
//  Each clk cycle it grants the RAM port to exactly one of three requesters:
//   1) display fetch, driven by p_tick, video_on, pixel_x and pixel_y;
//   2) a hardware screen clear;
//   3) a drawing/CPU writer using a valid/ack handshake.
//  It also produces the registered pixel colour for the VGA output.
// PARAMETERS
//  H_ACTIVE     640  active pixels per line
//  V_ACTIVE     480  active lines per frame
//  SCALE_SHIFT  2    log2 of the pixel replication factor; FB is 160x120 at the defaults
//  DATA_W       8    colour bits per FB word
//  ADDR_W       15   FB address width; FB_DEPTH = (H_ACTIVE>>SCALE_SHIFT)*(V_ACTIVE>>SCALE_SHIFT)
// PORTS
//  clk        in   1       system clock, single clock domain
//  reset      in   1       synchronous, active-low (asserted when reset==0, sampled on posedge clk)
//  p_tick     in   1       pixel strobe from Sincronizador; at most one p_tick every 2 clk cycles
//  video_on   in   1       active-video flag from Sincronizador
//  pixel_x    in   10      current pixel column
//  pixel_y    in   10      current pixel row
//  wr_req     in   1       writer has a valid write on wr_addr/wr_data
//  wr_addr    in   ADDR_W  writer FB address
//  wr_data    in   DATA_W  writer data
//  wr_ack     out  1       write accepted this cycle; the transfer happens at a posedge with wr_req&&wr_ack
//  clr_start  in   1       one-cycle pulse that starts a full-screen clear
//  clr_color  in   DATA_W  fill value, sampled on the clr_start cycle
//  clr_busy   out  1       a clear is in progress
//  mem_addr   out  ADDR_W  RAM address (combinational from the current grant)
//  mem_we     out  1       RAM write enable
//  mem_wdata  out  DATA_W  RAM write data
//  mem_rdata  in   DATA_W  RAM read data; synchronous RAM with 1-cycle read latency
//  rgb        out  DATA_W  registered pixel colour
// BEHAVIOUR
//  Reset (reset==0 at posedge)
//   - rgb=0, clr_busy=0, rd_pending=0, colour register=0, clear counter=0.
//   - While reset==0: mem_we=0 and wr_ack=0 (combinational).
//  Per-cycle grant, fixed priority display > clear > writer
//   - DISP, when p_tick=1 and video_on=1:
//     mem_addr = (pixel_y>>SCALE_SHIFT)*(H_ACTIVE>>SCALE_SHIFT) + (pixel_x>>SCALE_SHIFT); mem_we=0.
//   - CLR, else if clr_busy: mem_addr=clr_cnt, mem_we=1, mem_wdata=clr_col.
//   - WR, else if wr_req: wr_ack=1, mem_addr=wr_addr, mem_wdata=wr_data.
//     mem_we=1 only if wr_addr<FB_DEPTH; an out-of-range write is still acked and is discarded.
//   - Otherwise idle: mem_we=0, mem_addr holds the display address.
//  Display pipeline
//   - On a p_tick cycle, register rd_pending<=1 and vis<=video_on.
//   - Next cycle: rgb<=vis ? mem_rdata : 0.
//   - rgb changes on the 2nd posedge after the p_tick cycle, regardless of video_on.
//   - rgb holds its value between updates.
//  Clear FSM, states IDLE and CLEAR
//   - IDLE -> CLEAR on clr_start: clr_cnt<=0, clr_col<=clr_color, clr_busy<=1.
//   - In CLEAR, clr_cnt increments only on CLR-granted cycles.
//   - The grant with clr_cnt==FB_DEPTH-1 writes the last word and returns to IDLE, clr_busy<=0.
//   - clr_start while clr_busy is ignored (no restart, colour unchanged).
//   - Reset mid-clear aborts at once; no further clear writes. A later clr_start restarts at address 0.
//  Boundary conditions
//   - A writer can stall for the full duration of a clear; it is never starved by display.
//     A non-p_tick cycle always follows each p_tick cycle.
//   - wr_req may drop without an ack; nothing is written.
//   - pixel_x/pixel_y beyond the active area are never fetched, because video_on=0 there.
//  Arithmetic
//   - Address multiply is by a constant; truncate to ADDR_W.
//   - clr_cnt is ADDR_W bits and never wraps past FB_DEPTH-1.
// STRUCTURE
//  - vga_fb_pkg.vh (`include): FB_W, FB_H, FB_DEPTH localparams and the state encodings ST_IDLE, ST_CLEAR.
//  - One sub-module, vga_fb_addr_gen: combinational pixel_x/pixel_y -> FB address, parameterised like the top.
//  - Top level holds grant logic, clear FSM/counter and the display pipeline registers.
// TESTING
//  - Reset: hold reset=0 for 10 cycles, toggling wr_req/clr_start -> rgb=0, clr_busy=0, wr_ack=0, mem_we=0 throughout.
//  - Fetch: p_tick=1, video_on=1, pixel_x=8, pixel_y=4 -> mem_addr=162, mem_we=0;
//    RAM returns 0xA5 -> rgb=0xA5 from the 2nd edge after p_tick.
//  - Blank: p_tick=1, video_on=0 -> rgb=0 at the 2nd edge after p_tick; mem_rdata ignored.
//  - Contention: wr_req with addr 5 / data 0x3C raised on a p_tick+video_on cycle ->
//    wr_ack=0 that cycle; next cycle wr_ack=1, mem_we=1, mem_addr=5, mem_wdata=0x3C.
//  - Clear: clr_start with clr_color=0x11, video_on=0, wr_req=1 ->
//    exactly 19200 consecutive writes of 0x11 to addresses 0..19199, wr_ack=0 meanwhile;
//    clr_busy falls after addr 19199, then wr_ack=1.
//  - Abort/range: reset=0 when clr_cnt=100 -> no writes after that edge, clr_busy=0;
//    wr_addr=19200 -> wr_ack=1, mem_we=0.

Source files
------------

// File: rtl/vga_fb_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// vga_fb_arbiter_pkg
// Shared definitions for the VGA frame-buffer arbiter:
//   - default geometry of the visible area and of the down-scaled frame buffer
//   - clear-engine state encoding (ST_IDLE / ST_CLEAR)
//   - fb_depth(): number of frame-buffer words for a given geometry
// No ports (package).
// -----------------------------------------------------------------------------
package vga_fb_arbiter_pkg;

    localparam int unsigned DEF_H_ACTIVE    = 640;
    localparam int unsigned DEF_V_ACTIVE    = 480;
    localparam int unsigned DEF_SCALE_SHIFT = 2;
    localparam int unsigned DEF_DATA_W      = 8;
    localparam int unsigned DEF_ADDR_W      = 15;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } clr_state_t;

    // Words in the down-scaled frame buffer (160x120 = 19200 at the defaults).
    function automatic int unsigned fb_depth(input int unsigned h_active,
                                             input int unsigned v_active,
                                             input int unsigned scale_shift);
        return (h_active >> scale_shift) * (v_active >> scale_shift);
    endfunction

endpackage

// File: rtl/vga_fb_arbiter_addr_gen.sv
// -----------------------------------------------------------------------------
// vga_fb_addr_gen
// Combinational mapping from the current screen pixel to its frame-buffer word.
// Each FB word is replicated over a (2^SCALE_SHIFT)^2 block of screen pixels.
// Ports:
//   i_pixel_x  [9:0]        screen column
//   i_pixel_y  [9:0]        screen row
//   o_addr     [ADDR_W-1:0] FB address, row-major, truncated to ADDR_W
// -----------------------------------------------------------------------------
module vga_fb_addr_gen
    import vga_fb_arbiter_pkg::*;
#(
    parameter int unsigned H_ACTIVE    = DEF_H_ACTIVE,
    parameter int unsigned SCALE_SHIFT = DEF_SCALE_SHIFT,
    parameter int unsigned ADDR_W      = DEF_ADDR_W
) (
    input  logic [9:0]        i_pixel_x,
    input  logic [9:0]        i_pixel_y,
    output logic [ADDR_W-1:0] o_addr
);

    localparam int unsigned LINE_W = H_ACTIVE >> SCALE_SHIFT;

    logic [9:0] w_row;
    logic [9:0] w_col;

    assign w_row = i_pixel_y >> SCALE_SHIFT;
    assign w_col = i_pixel_x >> SCALE_SHIFT;

    // Constant multiply; all terms are widened to ADDR_W so the result wraps
    // (truncates) at the address width.
    assign o_addr = ADDR_W'(ADDR_W'(w_row) * ADDR_W'(LINE_W)) + ADDR_W'(w_col);

endmodule

// File: rtl/vga_fb_arbiter.sv
// -----------------------------------------------------------------------------
// vga_fb_arbiter
// Owns the single-port frame-buffer RAM behind the VGA timing generator and
// grants it each clk cycle to one requester, fixed priority:
//   display fetch (p_tick && video_on) > hardware clear > writer handshake.
// Also produces the registered pixel colour for the VGA output.
// Ports:
//   clk, reset                 clock; synchronous active-low reset
//   p_tick, video_on           pixel strobe / active-video flag
//   pixel_x, pixel_y [9:0]     current screen pixel
//   wr_req/wr_addr/wr_data     writer request; wr_ack (out) accepts it
//   clr_start, clr_color       start pulse and fill value for a full clear
//   clr_busy (out)             clear in progress
//   mem_addr/mem_we/mem_wdata  RAM port (combinational from the grant)
//   mem_rdata                  RAM read data, 1-cycle latency
//   rgb (out)                  registered pixel colour
// -----------------------------------------------------------------------------
module vga_fb_arbiter
    import vga_fb_arbiter_pkg::*;
#(
    parameter int unsigned H_ACTIVE    = DEF_H_ACTIVE,
    parameter int unsigned V_ACTIVE    = DEF_V_ACTIVE,
    parameter int unsigned SCALE_SHIFT = DEF_SCALE_SHIFT,
    parameter int unsigned DATA_W      = DEF_DATA_W,
    parameter int unsigned ADDR_W      = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              p_tick,
    input  logic              video_on,
    input  logic [9:0]        pixel_x,
    input  logic [9:0]        pixel_y,
    input  logic              wr_req,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_ack,
    input  logic              clr_start,
    input  logic [DATA_W-1:0] clr_color,
    output logic              clr_busy,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [DATA_W-1:0] rgb
);

    localparam int unsigned       FB_DEPTH  = fb_depth(H_ACTIVE, V_ACTIVE, SCALE_SHIFT);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FB_DEPTH - 1);

    // Writes beyond the frame buffer are acknowledged but must not reach the RAM.
    function automatic logic in_fb(input logic [ADDR_W-1:0] addr);
        return 32'(addr) < FB_DEPTH;
    endfunction

    logic [ADDR_W-1:0] w_disp_addr;

    clr_state_t        r_state;
    clr_state_t        w_state_nxt;
    logic [ADDR_W-1:0] r_clr_cnt;
    logic [ADDR_W-1:0] w_clr_cnt_nxt;
    logic [DATA_W-1:0] r_clr_col;
    logic [DATA_W-1:0] w_clr_col_nxt;

    logic              w_gnt_disp;
    logic              w_gnt_clr;
    logic              w_gnt_wr;

    logic              r_vld_p1;
    logic              r_vis_p1;
    logic [DATA_W-1:0] r_rgb_p2;

    vga_fb_addr_gen #(
        .H_ACTIVE    (H_ACTIVE),
        .SCALE_SHIFT (SCALE_SHIFT),
        .ADDR_W      (ADDR_W)
    ) u_addr_gen (
        .i_pixel_x (pixel_x),
        .i_pixel_y (pixel_y),
        .o_addr    (w_disp_addr)
    );

    assign clr_busy = (r_state == ST_CLEAR);

    // Grant: display pre-empts everything, but p_tick never arrives on two
    // consecutive cycles, so the clear and the writer always make progress.
    assign w_gnt_disp = p_tick && video_on;
    assign w_gnt_clr  = !w_gnt_disp && clr_busy;
    assign w_gnt_wr   = !w_gnt_disp && !clr_busy && wr_req;

    always_comb begin
        mem_addr  = w_disp_addr;
        mem_we    = 1'b0;
        mem_wdata = '0;
        wr_ack    = 1'b0;
        // While reset is held no requester may touch the RAM.
        if (reset) begin
            if (w_gnt_clr) begin
                mem_addr  = r_clr_cnt;
                mem_we    = 1'b1;
                mem_wdata = r_clr_col;
            end else if (w_gnt_wr) begin
                wr_ack    = 1'b1;
                mem_addr  = wr_addr;
                mem_we    = in_fb(wr_addr);
                mem_wdata = wr_data;
            end
        end
    end

    // Clear engine next state: clr_start is only honoured from IDLE, and the
    // counter only advances on cycles the clear actually owned the RAM.
    always_comb begin
        w_state_nxt   = r_state;
        w_clr_cnt_nxt = r_clr_cnt;
        w_clr_col_nxt = r_clr_col;
        case (r_state)
            ST_IDLE: begin
                if (clr_start) begin
                    w_state_nxt   = ST_CLEAR;
                    w_clr_cnt_nxt = '0;
                    w_clr_col_nxt = clr_color;
                end
            end
            ST_CLEAR: begin
                if (w_gnt_clr) begin
                    if (r_clr_cnt == LAST_ADDR) begin
                        w_state_nxt   = ST_IDLE;
                        w_clr_cnt_nxt = '0;
                    end else begin
                        w_clr_cnt_nxt = r_clr_cnt + 1'b1;
                    end
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state   <= ST_IDLE;
            r_clr_cnt <= '0;
            r_clr_col <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_clr_cnt <= w_clr_cnt_nxt;
            r_clr_col <= w_clr_col_nxt;
        end
    end

    // ---- stage p1: fetch issued on the p_tick cycle, remember visibility ----
    // ---- stage p2: RAM data valid, latch colour (black outside video)   ----
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_vld_p1 <= 1'b0;
            r_vis_p1 <= 1'b0;
            r_rgb_p2 <= '0;
        end else begin
            r_vld_p1 <= p_tick;
            if (p_tick) begin
                r_vis_p1 <= video_on;
            end
            if (r_vld_p1) begin
                r_rgb_p2 <= r_vis_p1 ? mem_rdata : '0;
            end
        end
    end

    assign rgb = r_rgb_p2;

endmodule

// File: tb/tb_vga_fb_arbiter.sv
module tb_vga_fb_arbiter;

    localparam int ADDR_W = 15;
    localparam int DATA_W = 8;
    localparam int DEPTH  = 19200;
    localparam int LINE   = 160;

    logic              clk = 1'b0;
    logic              reset;
    logic              p_tick;
    logic              video_on;
    logic [9:0]        pixel_x;
    logic [9:0]        pixel_y;
    logic              wr_req;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              wr_ack;
    logic              clr_start;
    logic [DATA_W-1:0] clr_color;
    logic              clr_busy;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_we;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic [DATA_W-1:0] rgb;

    always #5 clk = ~clk;

    vga_fb_arbiter dut (
        .clk       (clk),
        .reset     (reset),
        .p_tick    (p_tick),
        .video_on  (video_on),
        .pixel_x   (pixel_x),
        .pixel_y   (pixel_y),
        .wr_req    (wr_req),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .wr_ack    (wr_ack),
        .clr_start (clr_start),
        .clr_color (clr_color),
        .clr_busy  (clr_busy),
        .mem_addr  (mem_addr),
        .mem_we    (mem_we),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .rgb       (rgb)
    );

    // Synchronous single-port RAM attached to the DUT, read-first.
    logic [7:0] ram [0:32767];
    always @(posedge clk) begin
        if (mem_we) ram[mem_addr] <= mem_wdata;
        mem_rdata <= ram[mem_addr];
    end

    // Reference model: expected frame-buffer contents and clear progress.
    logic [7:0] ref_mem [0:32767];
    bit         m_busy = 0;
    int         m_next = 0;
    int         m_col  = 0;

    typedef struct { int addr; int data; } wr_t;
    typedef struct { int due;  int val;  } px_t;
    wr_t exp_wr[$];
    px_t exp_px[$];

    int cyc    = 0;
    int errors = 0;
    int checks = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: compares every RAM write the DUT issues and every due pixel.
    initial begin : monitor
        wr_t w;
        px_t p;
        forever begin
            @(negedge clk);
            if (mem_we === 1'b1) begin
                if (exp_wr.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_write: got addr %0d data %0d expected no write (cycle %0d)",
                             mem_addr, mem_wdata, cyc);
                end else begin
                    w = exp_wr.pop_front();
                    chk("wr_addr", int'(mem_addr), w.addr);
                    chk("wr_data", int'(mem_wdata), w.data);
                end
            end
            while (exp_px.size() > 0 && exp_px[0].due <= cyc) begin
                p = exp_px.pop_front();
                chk("rgb", int'(rgb), p.val);
            end
        end
    end

    // One clock cycle of stimulus; the model predicts the grant from the rules.
    task automatic step(input bit rst_n, input bit pt, input bit von,
                        input int px, input int py,
                        input bit wq, input int wa, input int wd,
                        input bit cs, input int cc);
        int  k;
        int  a;
        bit  exp_ack;
        bit  exp_busy;
        px_t p;
        wr_t w;
        @(posedge clk);
        #1;
        reset     = rst_n;
        p_tick    = pt;
        video_on  = von;
        pixel_x   = 10'(px);
        pixel_y   = 10'(py);
        wr_req    = wq;
        wr_addr   = ADDR_W'(wa);
        wr_data   = 8'(wd);
        clr_start = cs;
        clr_color = 8'(cc);
        k        = cyc;
        exp_ack  = 0;
        exp_busy = m_busy;
        a        = (py / 4) * LINE + (px / 4);
        if (!rst_n) begin
            m_busy = 0;
            m_next = 0;
        end else begin
            if (pt) begin
                p.due = k + 2;
                p.val = von ? int'(ref_mem[a]) : 0;
                exp_px.push_back(p);
            end
            if (pt && von) begin
                // display owns the RAM this cycle
            end else if (m_busy) begin
                w.addr = m_next;
                w.data = m_col;
                exp_wr.push_back(w);
                ref_mem[m_next] = 8'(m_col);
                if (m_next == DEPTH - 1) begin
                    m_busy = 0;
                    m_next = 0;
                end else begin
                    m_next++;
                end
            end else if (wq) begin
                exp_ack = 1;
                if (wa < DEPTH) begin
                    w.addr = wa;
                    w.data = wd & 8'hFF;
                    exp_wr.push_back(w);
                    ref_mem[wa] = 8'(wd);
                end
            end
            if (cs && !exp_busy) begin
                m_busy = 1;
                m_next = 0;
                m_col  = cc & 8'hFF;
            end
        end
        @(negedge clk);
        chk("wr_ack", int'(wr_ack), int'(exp_ack));
        chk("clr_busy", int'(clr_busy), int'(exp_busy));
        if (!rst_n) chk("mem_we_in_reset", int'(mem_we), 0);
        if (rst_n && pt && von) begin
            chk("disp_addr", int'(mem_addr), a);
            chk("disp_we", int'(mem_we), 0);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin : watchdog
        #3ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : stim
        bit last_pt;
        bit pt;
        bit von;
        int px;
        int py;
        for (int i = 0; i < 32768; i++) begin
            ram[i]     = 8'((i * 37 + 11) & 255);
            ref_mem[i] = 8'((i * 37 + 11) & 255);
        end
        ram[162]     = 8'hA5;
        ref_mem[162] = 8'hA5;
        reset = 0; p_tick = 0; video_on = 0; pixel_x = 0; pixel_y = 0;
        wr_req = 0; wr_addr = 0; wr_data = 0; clr_start = 0; clr_color = 0;

        // Reset held with requests toggling.
        for (int i = 0; i < 10; i++) begin
            step(0, 0, 0, 0, 0, i[0], 3, 8'h44, i[0], 8'h77);
            if (i > 0) chk("rgb_in_reset", int'(rgb), 0);
        end

        // Fetch of address 162 (x=8, y=4).
        step(1, 1, 1, 8, 4, 0, 0, 0, 0, 0);
        idle(2);
        // Blank pixel: rgb goes to 0 although RAM holds 0xA5.
        step(1, 1, 0, 8, 4, 0, 0, 0, 0, 0);
        idle(2);

        // Contention: display wins, writer served the next cycle.
        step(1, 1, 1, 0, 0, 1, 5, 8'h3C, 0, 0);
        step(1, 0, 1, 0, 0, 1, 5, 8'h3C, 0, 0);
        idle(2);

        // Out-of-range write: acked, not written.
        step(1, 0, 0, 0, 0, 1, DEPTH, 8'h77, 0, 0);
        // Request dropped before being served during a display cycle.
        step(1, 1, 1, 40, 40, 1, 9, 8'h12, 0, 0);
        idle(2);

        // Full clear with a writer stalled; a second start mid-clear is ignored.
        step(1, 0, 0, 0, 0, 1, 7, 8'h99, 1, 8'h11);
        for (int i = 0; i < 20000 && m_busy; i++)
            step(1, 0, 0, 0, 0, 1, 7, 8'h99, (i == 50), 8'h22);
        step(1, 0, 0, 0, 0, 1, 7, 8'h99, 0, 0);
        idle(1);
        step(1, 1, 1, 20, 20, 0, 0, 0, 0, 0);
        idle(2);

        // Randomised traffic.
        last_pt = 0;
        for (int i = 0; i < 3000; i++) begin
            pt  = last_pt ? 1'b0 : 1'($urandom_range(0, 1));
            von = 1'($urandom_range(0, 3) != 0);
            if (von) begin
                px = $urandom_range(0, 639);
                py = $urandom_range(0, 479);
            end else begin
                px = $urandom_range(0, 1023);
                py = $urandom_range(0, 1023);
            end
            step(1, pt, von, px, py, 1'($urandom_range(0, 1)),
                 $urandom_range(0, DEPTH + 100), $urandom_range(0, 255), 0, 0);
            last_pt = pt;
        end
        idle(3);

        // Abort a clear when the counter reaches 100, then restart it.
        step(1, 0, 0, 0, 0, 0, 0, 0, 1, 8'h55);
        for (int i = 0; i < 200 && m_next < 100; i++) idle(1);
        step(0, 0, 0, 0, 0, 1, 3, 8'h01, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0, 1, 8'h66);
        idle(6);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        idle(3);
        step(1, 1, 1, 0, 0, 0, 0, 0, 0, 0);
        idle(3);

        chk("pending_writes_left", exp_wr.size(), 0);
        chk("pending_pixels_left", exp_px.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
